// File: rtl/alu_pipe.sv
// Handshaked pipelined ALU: one op per valid/ready transfer, registered result with
// zero/error flags, held until the consumer accepts it. Multiply is shift-and-add over WIDTH cycles.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [3:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_sum, alu_res;
    logic [SHW-1:0]   cnt, shamt;
    logic             alu_err, accept, is_mul, mul_last;

    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (ALUop == 4'd10) && (MUL_EN != 0);
    assign shamt     = opB[SHW-1:0];
    assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
    assign mul_last  = (cnt == SHW'(WIDTH - 1));

    // Single-cycle operations; anything not listed (including mul when disabled) is illegal.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (ALUop)
            4'd0:    alu_res = opA + opB;
            4'd1:    alu_res = opA - opB;
            4'd2:    alu_res = opA & opB;
            4'd3:    alu_res = opA | opB;
            4'd4:    alu_res = opA ^ opB;
            4'd5:    alu_res = opA << shamt;
            4'd6:    alu_res = opA >> shamt;
            4'd7:    alu_res = $unsigned($signed(opA) >>> shamt);
            4'd8:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            4'd9:    alu_res = {{(WIDTH-1){1'b0}}, (opA < opB)};
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = is_mul ? MUL : HOLD;
            MUL:  if (mul_last) state_next = HOLD;
            HOLD: begin
                if (accept)         state_next = is_mul ? MUL : HOLD;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // The final multiply iteration writes acc_sum straight into result so latency is exactly WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= opA;
                mplier <= opB;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                result <= alu_res;
                zero   <= (alu_res == '0);
                err    <= alu_err;
            end
        end else if (state == MUL) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (mul_last) begin
                result <= acc_sum;
                zero   <= (acc_sum == '0);
                err    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes reference results on acceptance,
// an independent monitor pops and compares on every output transfer.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic [3:0]  ALUop = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        err;

    int checks = 0;
    int failures = 0;
    logic [33:0] expQ[$];

    alu_pipe #(.WIDTH(32), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opA(opA), .opB(opB), .ALUop(ALUop), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model from the opcode table; packed as {err, zero, result}.
    function automatic logic [33:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] p;
        int          s;
        logic        e;
        s = int'(b % 32);
        e = 1'b0;
        r = '0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << s;
            4'd6: r = a >> s;
            4'd7: r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd8: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                p = {32'h0, a} * {32'h0, b};
                r = p[31:0];
            end
            default: e = 1'b1;
        endcase
        return {e, (r == 32'h0), r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Presents one op and holds it until accepted; returns the number of cycles it waited.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int waited);
        bit taken;
        taken = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        ALUop = op;
        opA = a;
        opB = b;
        while (!taken && waited < 200) begin
            @(negedge clk);
            if (in_ready) begin
                expQ.push_back(refModel(op, a, b));
                taken = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", result, 32'hDEAD_BEEF);
            end else begin
                logic [33:0] e;
                e = expQ.pop_front();
                checkOutput("result", result, e[31:0]);
                checkOutput("zero", {31'h0, zero}, {31'h0, e[32]});
                checkOutput("err", {31'h0, err}, {31'h0, e[33]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  w;
        int  lat;
        int  bad;
        bit  done;
        logic [3:0] rop;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", {31'h0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'h0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_zero", {31'h0, zero}, 32'd0);
        checkOutput("reset_err", {31'h0, err}, 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("idle_out_valid", {31'h0, out_valid}, 32'd0);
        checkOutput("idle_result", result, 32'd0);
        checkOutput("idle_in_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back ops");
        out_ready = 1'b1;
        applyStimulus(4'd0, 32'hFFFF_FFFF, 32'd1, w);
        checkOutput("b2b_wait_add", w, 0);
        applyStimulus(4'd1, 32'd3, 32'd5, w);
        checkOutput("b2b_wait_sub", w, 0);
        applyStimulus(4'd7, 32'h8000_0000, 32'h24, w);
        checkOutput("b2b_wait_sra", w, 0);
        applyStimulus(4'd8, 32'hFFFF_FFFF, 32'd1, w);
        applyStimulus(4'd9, 32'hFFFF_FFFF, 32'd1, w);
        applyStimulus(4'd5, 32'd1, 32'h21, w);

        $display("[TB] multiply latency");
        applyStimulus(4'd10, 32'hFFFF_FFFD, 32'd7, w);
        lat = 0;
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) begin
                in_valid = 1'b1;
                ALUop = 4'd0;
                opA = 32'd1;
                opB = 32'd1;
            end
            if (k == 6) in_valid = 1'b0;
            if (out_valid) begin
                lat = k;
                break;
            end
            if (in_ready) bad++;
        end
        checkOutput("mul_latency", lat, 32);
        checkOutput("mul_in_ready_low", bad, 0);
        checkOutput("mul_direct_result", result, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(4'd4, 32'h0000_F0F0, 32'h0000_0FF0, w);
        fork
            applyStimulus(4'd0, 32'd100, 32'd23, w);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checkOutput("bp_result", result, 32'h0000_FF00);
                    checkOutput("bp_out_valid", {31'h0, out_valid}, 32'd1);
                    checkOutput("bp_in_ready", {31'h0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        checkOutput("bp_wait", w, 4);

        applyStimulus(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, w);

        $display("[TB] random ops");
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    rop = 4'($urandom_range(0, 15));
                    applyStimulus(rop, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom, w);
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 200 && expQ.size() != 0; k++) @(posedge clk);
        checkOutput("drain_random", expQ.size(), 0);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-multiply");
        applyStimulus(4'd10, 32'h0001_2345, 32'h0000_0777, w);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd1);
        checkOutput("rst_result", result, 32'd0);
        expQ.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        checkOutput("no_stale_output", bad, 0);
        @(posedge clk);
        #1;
        applyStimulus(4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, w);
        for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
        checkOutput("drain_final", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
